// File: rtl/vmem_pkg.sv
// Shared constants for the vector memory sequencer: state codes, word width
// and lane-slice helpers.
package vmem_pkg;

  localparam int WORD       = 32;
  localparam int NLANES_DEF = 5;
  localparam int VSIZE_W    = 3;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_ISSUE  = 3'd1;
  localparam state_t ST_WAIT_R = 3'd2;
  localparam state_t ST_DONE   = 3'd3;
  localparam state_t ST_ERR    = 3'd4;

  function automatic int lane_lo(input int idx);
    return idx * WORD;
  endfunction

endpackage

// File: rtl/vmem_lane_buf.sv
// Load capture bank: NLANES 32-bit lanes, cleared on load accept, one lane
// written per returned word.
module vmem_lane_buf
  import vmem_pkg::*;
#(
  parameter int NLANES = NLANES_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [VSIZE_W-1:0]       idx,
  input  logic [WORD-1:0]          wdata,
  output logic [WORD*NLANES-1:0]   lanes
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      lanes <= '0;
    end else if (clear) begin
      lanes <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NLANES; i++) begin
        if (idx == VSIZE_W'(i)) lanes[lane_lo(i) +: WORD] <= wdata;
      end
    end
  end

endmodule

// File: rtl/vmem_seq.sv
// Vector load/store sequencer: splits one vector request into per-element
// word accesses and stalls the datapath until the whole vector completes.
//
// state   | meaning
// IDLE    | waiting for start; busy low
// ISSUE   | element k request held on the memory port until granted
// WAIT_R  | load element k granted, waiting for its read return
// DONE    | one-cycle completion pulse
// ERR     | one-cycle rejection pulse for a malformed request
module vmem_seq
  import vmem_pkg::*;
#(
  parameter int NLANES = NLANES_DEF,
  parameter int AW     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    is_store,
  input  logic [AW-1:0]           base_addr,
  input  logic [VSIZE_W-1:0]      vsize,
  input  logic [WORD*NLANES-1:0]  wlanes,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [WORD*NLANES-1:0]  rlanes,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [AW-1:0]           mem_addr,
  output logic [WORD-1:0]         mem_wdata,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [WORD-1:0]         mem_rdata
);

  state_t                  state;
  logic [VSIZE_W-1:0]      k;
  logic [VSIZE_W-1:0]      vsize_r;
  logic [AW-1:0]           base_r;
  logic                    store_r;
  logic [WORD*NLANES-1:0]  wlanes_r;

  logic                    req_bad;
  logic                    last;
  logic                    issue;
  logic [WORD-1:0]         lane_k;

  assign req_bad = (vsize == '0) || (int'(vsize) > NLANES) || (base_addr[1:0] != 2'b00);
  assign last    = (k == vsize_r - VSIZE_W'(1));
  assign issue   = (state == ST_ISSUE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      k        <= '0;
      vsize_r  <= '0;
      base_r   <= '0;
      store_r  <= 1'b0;
      wlanes_r <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            base_r   <= base_addr;
            vsize_r  <= vsize;
            store_r  <= is_store;
            wlanes_r <= wlanes;
            k        <= '0;
            state    <= req_bad ? ST_ERR : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_gnt) begin
            if (store_r) begin
              k     <= k + VSIZE_W'(1);
              state <= last ? ST_DONE : ST_ISSUE;
            end else begin
              state <= ST_WAIT_R;
            end
          end
        end
        ST_WAIT_R: begin
          if (mem_rvalid) begin
            if (last) begin
              state <= ST_DONE;
            end else begin
              k     <= k + VSIZE_W'(1);
              state <= ST_ISSUE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    lane_k = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (k == VSIZE_W'(i)) lane_k = wlanes_r[lane_lo(i) +: WORD];
    end
  end

  // Port outputs are forced to zero outside ISSUE so the bus is quiet when idle.
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign err       = (state == ST_ERR);
  assign mem_req   = issue;
  assign mem_we    = issue & store_r;
  assign mem_addr  = issue ? base_r + AW'({k, 2'b00}) : '0;
  assign mem_wdata = issue ? lane_k : '0;

  vmem_lane_buf #(.NLANES(NLANES)) u_lane_buf (
    .clk   (clk),
    .reset (reset),
    .clear (state == ST_IDLE && start && !is_store && !req_bad),
    .wr_en (state == ST_WAIT_R && mem_rvalid),
    .idx   (k),
    .wdata (mem_rdata),
    .lanes (rlanes)
  );

endmodule

// File: tb/tb_vmem_seq.sv
// Randomized bench for vmem_seq: the bench plays the memory and predicts
// request sequences, latencies and load results from per-element delays.
module tb_vmem_seq;

  localparam int NL = 5;
  localparam int VW = 32 * NL;

  logic           clk = 1'b0;
  logic           reset, start, is_store, mem_gnt, mem_rvalid;
  logic [31:0]    base_addr, mem_rdata;
  logic [2:0]     vsize;
  logic [VW-1:0]  wlanes, rlanes;
  logic           busy, done, err, mem_req, mem_we;
  logic [31:0]    mem_addr, mem_wdata;

  vmem_seq #(.NLANES(NL), .AW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_store   (is_store),
    .base_addr  (base_addr),
    .vsize      (vsize),
    .wlanes     (wlanes),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rlanes     (rlanes),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rl [NL];

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] model_rlanes();
    logic [VW-1:0] v;
    for (int i = 0; i < NL; i++) v[i*32 +: 32] = exp_rl[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One vector transaction; g0 >= 0 forces the grant wait on element 0.
  task automatic run_op(input bit st, input logic [31:0] base, input int n, input int gmax,
                        input int rmax, input int g0, input bit stray, input logic [31:0] salt);
    int g[NL];
    int r[NL];
    logic [31:0] wl[NL];
    int exp_done, ek, wcnt, rv_due;
    logic [31:0] rv_addr, ea;
    logic [VW-1:0] wv;
    for (int i = 0; i < NL; i++) begin
      g[i] = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
      r[i] = int'($urandom_range(rmax, 1));
    end
    if (g0 >= 0) g[0] = g0;
    exp_done = 1;
    for (int i = 0; i < n; i++) exp_done += g[i] + 1 + (st ? 0 : r[i]);
    for (int i = 0; i < NL; i++) begin
      wl[i] = $urandom;
      wv[i*32 +: 32] = wl[i];
    end
    start = 1'b1; is_store = st; base_addr = base; vsize = 3'(n); wlanes = wv;
    if (!st) for (int i = 0; i < NL; i++) exp_rl[i] = '0;
    ek = 0; wcnt = g[0]; rv_due = -1; rv_addr = '0;
    for (int t = 1; t <= exp_done + 1; t++) begin
      tick();
      start = (stray && t == 2);
      is_store = 1'($urandom); base_addr = $urandom; vsize = 3'($urandom); wlanes = '1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      chk("busy", VW'(busy), VW'(t <= exp_done));
      chk("done", VW'(done), VW'(t == exp_done));
      chk("err", VW'(err), '0);
      chk("req", VW'(mem_req), VW'(ek < n && rv_due < 0 && t < exp_done));
      if (ek < n && rv_due < 0 && t < exp_done) begin
        ea = base + 32'(4 * ek);
        chk("addr", VW'(mem_addr), VW'(ea));
        chk("we", VW'(mem_we), VW'(st));
        chk("wdata", VW'(mem_wdata), VW'(wl[ek]));
        if (wcnt == 0) begin
          mem_gnt = 1'b1;
          if (!st) begin
            rv_due = t + r[ek];
            rv_addr = ea;
          end
          ek++;
          if (ek < n) wcnt = g[ek];
        end else begin
          wcnt--;
        end
      end else begin
        mem_gnt = 1'($urandom);
      end
      if (t == rv_due) begin
        mem_rvalid = 1'b1;
        mem_rdata = rv_addr ^ 32'h0000_A5A5 ^ salt;
        exp_rl[ek-1] = mem_rdata;
        rv_due = -1;
      end else if (rv_due < 0) begin
        mem_rvalid = ($urandom_range(3, 0) == 0);
      end
      if (t >= exp_done) chk("rlanes", rlanes, model_rlanes());
    end
    start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic run_err(input logic [31:0] base, input logic [2:0] vs, input bit st);
    start = 1'b1; is_store = st; base_addr = base; vsize = vs; wlanes = '1;
    tick();
    start = 1'b0;
    chk("err_pulse", VW'(err), VW'(1));
    chk("err_busy", VW'(busy), VW'(1));
    chk("err_req", VW'(mem_req), '0);
    chk("err_done", VW'(done), '0);
    tick();
    chk("err_clear", VW'(err), '0);
    chk("err_idle", VW'(busy), '0);
    chk("err_req2", VW'(mem_req), '0);
    chk("err_rlanes", rlanes, model_rlanes());
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; is_store = 1'b0; base_addr = '0; vsize = '0;
    wlanes = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    for (int i = 0; i < NL; i++) exp_rl[i] = '0;
    tick(); tick();
    chk("rst_busy", VW'(busy), '0);
    chk("rst_done", VW'(done), '0);
    chk("rst_err", VW'(err), '0);
    chk("rst_req", VW'(mem_req), '0);
    chk("rst_we", VW'(mem_we), '0);
    chk("rst_addr", VW'(mem_addr), '0);
    chk("rst_wdata", VW'(mem_wdata), '0);
    chk("rst_rlanes", rlanes, '0);
    reset = 1'b1;
    tick();

    run_op(1'b1, 32'h100, 3, 0, 1, -1, 1'b0, 32'h0);
    run_op(1'b0, 32'h200, 5, 0, 1, -1, 1'b0, 32'h0);
    run_op(1'b1, 32'h300, 2, 0, 1, 3, 1'b0, 32'h0);
    run_err(32'h400, 3'd0, 1'b0);
    run_err(32'h400, 3'd6, 1'b0);
    run_err(32'h400, 3'd7, 1'b1);
    run_err(32'h102, 3'd2, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFC, 2, 0, 1, -1, 1'b1, 32'h0);

    for (int i = 0; i < 30; i++) begin
      int n;
      n = int'($urandom_range(NL, 1));
      run_op(1'($urandom), $urandom & 32'hFFFF_FFFC, n, 3, 3, -1,
             (n >= 2) && 1'($urandom), $urandom);
      if ($urandom_range(3, 0) == 0) tick();
    end

    // Reset while the first element of a 4-element load is awaiting its return.
    start = 1'b1; is_store = 1'b0; base_addr = 32'h300; vsize = 3'd4; wlanes = '1;
    tick();
    start = 1'b0;
    chk("rr_req", VW'(mem_req), VW'(1));
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("rr_wait", VW'(busy && !mem_req), VW'(1));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < NL; i++) exp_rl[i] = '0;
    chk("rr_busy", VW'(busy), '0);
    chk("rr_req0", VW'(mem_req), '0);
    chk("rr_rlanes", rlanes, model_rlanes());
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      tick();
      mem_rvalid = 1'b0;
      chk("rr_nodone", VW'(done), '0);
      chk("rr_idle", VW'(busy), '0);
      chk("rr_rl", rlanes, model_rlanes());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
